// File: rtl/paddle_ai_controller_if.sv
// ---------------------------------------------------------------------------
// paddle_ai_controller_if
//   Signal bundle between the game top level and the computer-opponent
//   paddle controller.
//
//   master : game side. Drives the game/ball/paddle status and receives
//            the move commands.
//   slave  : controller side. Receives the status and drives the commands.
//
//   game_on     1 = play in progress
//   ball_y      ball centre row, same axis as paddle_pos
//   ball_toward 1 = ball moving toward this paddle
//   paddle_pos  paddle centre pixel reported by the Paddle instance
//   up / down   move commands to the Paddle instance
//   tracking    1 while the controller is following the ball
// ---------------------------------------------------------------------------
interface paddle_ai_controller_if #(
  parameter int POS_W = 10
);
  logic             game_on;
  logic [POS_W-1:0] ball_y;
  logic             ball_toward;
  logic [POS_W-1:0] paddle_pos;
  logic             up;
  logic             down;
  logic             tracking;

  modport master (
    output game_on, ball_y, ball_toward, paddle_pos,
    input  up, down, tracking
  );

  modport slave (
    input  game_on, ball_y, ball_toward, paddle_pos,
    output up, down, tracking
  );
endinterface

// File: rtl/paddle_ai_controller.sv
// ---------------------------------------------------------------------------
// paddle_ai_controller
//   Computer opponent for a Paddle instance. While the ball approaches it
//   re-samples the ball row every REACT_TICKS cycles and steers the paddle
//   toward it; while the ball recedes it steers back to the screen centre.
//   A deadband around the target keeps the paddle from jittering, and a wall
//   guard keeps it from being driven past either end of its range.
//
//   Ports
//     clk    in  system clock
//     reset  in  asynchronous, active-low reset
//     bus    slave side of paddle_ai_controller_if
//              in : game_on, ball_y, ball_toward, paddle_pos
//              out: up, down, tracking (all registered)
// ---------------------------------------------------------------------------
module paddle_ai_controller #(
  parameter int Y_RES       = 600,
  parameter int POS_W       = 10,
  parameter int REACT_TICKS = 25,
  parameter int DEADBAND    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  paddle_ai_controller_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_CENTER = 2'd2
  } state_t;

  localparam int TW = (REACT_TICKS > 1) ? $clog2(REACT_TICKS) : 1;

  localparam logic [POS_W-1:0]        Y_MAX   = POS_W'(Y_RES);
  localparam logic [POS_W-1:0]        Y_MID   = POS_W'(Y_RES / 2);
  localparam logic [TW-1:0]           T_LAST  = TW'(REACT_TICKS - 1);
  localparam logic signed [POS_W:0]   ERR_ZERO = '0;
  localparam logic signed [POS_W:0]   DB_POS  = (POS_W+1)'(DEADBAND);
  localparam logic signed [POS_W:0]   DB_NEG  = (POS_W+1)'(-DEADBAND);

  state_t             state_reg,  state_next;
  logic [TW-1:0]      timer_reg,  timer_next;
  logic [POS_W-1:0]   target_reg, target_next;
  logic               up_reg,     up_next;
  logic               down_reg,   down_next;
  logic               tracking_reg;

  logic [POS_W-1:0]   ball_clamped;
  logic signed [POS_W:0] err;

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      timer_reg    <= '0;
      target_reg   <= Y_MID;
      up_reg       <= 1'b0;
      down_reg     <= 1'b0;
      tracking_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      target_reg   <= target_next;
      up_reg       <= up_next;
      down_reg     <= down_next;
      tracking_reg <= (state_next == ST_TRACK);
    end
  end

  // -------------------------------------------------------------------------
  // Next-state, reaction timer, target and command logic
  // -------------------------------------------------------------------------
  assign ball_clamped = (bus.ball_y > Y_MAX) ? Y_MAX : bus.ball_y;

  // Both operands zero-extended, so the POS_W+1 bit difference cannot overflow.
  assign err = $signed({1'b0, target_reg}) - $signed({1'b0, bus.paddle_pos});

  always_comb begin
    state_next  = state_reg;
    timer_next  = '0;
    target_next = target_reg;
    up_next     = 1'b0;
    down_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (bus.game_on) state_next = bus.ball_toward ? ST_TRACK : ST_CENTER;
      end
      ST_TRACK: begin
        if (!bus.game_on)         state_next = ST_IDLE;
        else if (!bus.ball_toward) state_next = ST_CENTER;
      end
      ST_CENTER: begin
        if (!bus.game_on)         state_next = ST_IDLE;
        else if (bus.ball_toward) state_next = ST_TRACK;
      end
      default: state_next = ST_IDLE;
    endcase

    // The timer only runs while the state is held; any transition restarts
    // it, so a fresh target always arrives REACT_TICKS cycles after entry.
    if ((state_next == state_reg) && (state_reg != ST_IDLE)) begin
      if (timer_reg == T_LAST) begin
        target_next = (state_reg == ST_TRACK) ? ball_clamped : Y_MID;
      end else begin
        timer_next = timer_reg + TW'(1);
      end
    end

    // Hysteresis: a move starts only outside the deadband but runs until the
    // target is reached or passed. A moving paddle can only stop, so any
    // reversal is separated by at least one stopped cycle.
    if (state_next != ST_IDLE) begin
      if (up_reg) begin
        up_next = (err > ERR_ZERO);
      end else if (down_reg) begin
        down_next = (err < ERR_ZERO);
      end else begin
        up_next   = (err > DB_POS);
        down_next = (err < DB_NEG);
      end
      // Wall guard: never command motion into either end of the range.
      if (bus.paddle_pos >= Y_MAX) up_next   = 1'b0;
      if (bus.paddle_pos == '0)    down_next = 1'b0;
    end
  end

  assign bus.up       = up_reg;
  assign bus.down     = down_reg;
  assign bus.tracking = tracking_reg;

endmodule

// File: tb/tb_paddle_ai_controller.sv
// ---------------------------------------------------------------------------
// tb_paddle_ai_controller
//   Scenario tasks plus a randomized closed-loop run. The reference model
//   tracks the opponent's behaviour in plain terms: current mode, cycles
//   spent in that mode, current aim point and current command, and moves a
//   simple paddle model from the expected commands.
// ---------------------------------------------------------------------------
module tb_paddle_ai_controller;

  localparam int Y_RES = 600;
  localparam int POS_W = 10;
  localparam int REACT = 25;
  localparam int DB    = 8;

  logic clk = 1'b0;
  logic reset;

  paddle_ai_controller_if #(.POS_W(POS_W)) bus();

  paddle_ai_controller #(
    .Y_RES(Y_RES), .POS_W(POS_W), .REACT_TICKS(REACT), .DEADBAND(DB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = idle, 1 = chasing the ball, 2 = returning home
  int m_mode;
  int m_age;
  int m_target;
  bit m_up;
  bit m_down;
  int pp;  // paddle position driven into the DUT

  task automatic model_reset();
    m_mode = 0; m_age = 0; m_target = Y_RES / 2; m_up = 0; m_down = 0;
  endtask

  // Advance the model by one clock edge using the inputs held across it.
  task automatic model_step();
    int nm, err, by;
    bit nu, nd;
    nm  = !bus.game_on ? 0 : (bus.ball_toward ? 1 : 2);
    err = m_target - int'(bus.paddle_pos);
    nu = 0; nd = 0;
    if (nm != 0) begin
      if (m_up)        nu = (err > 0);
      else if (m_down) nd = (err < 0);
      else begin
        nu = (err > DB);
        nd = (err < -DB);
      end
      if (int'(bus.paddle_pos) >= Y_RES) nu = 0;
      if (int'(bus.paddle_pos) == 0)     nd = 0;
    end
    if (nm == 0 || nm != m_mode) begin
      m_age = 0;
    end else begin
      m_age++;
      if (m_age % REACT == 0) begin
        by = int'(bus.ball_y);
        m_target = (nm == 1) ? ((by > Y_RES) ? Y_RES : by) : Y_RES / 2;
      end
    end
    m_mode = nm; m_up = nu; m_down = nd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  // The paddle follows the expected commands, clamped to its range.
  task automatic move_paddle();
    pp = pp + int'(m_up) - int'(m_down);
    if (pp < 0) pp = 0;
    if (pp > Y_RES) pp = Y_RES;
    bus.paddle_pos = POS_W'(pp);
  endtask

  task automatic set_pos(input int p);
    pp = p;
    bus.paddle_pos = POS_W'(p);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    bus.game_on = 1'b0; bus.ball_y = '0; bus.ball_toward = 1'b0;
    set_pos(300);
    model_reset();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.up, bus.down, bus.tracking} !== 3'b000) begin
        errors++;
        $display("FAIL reset_state c=%0d got up/down/trk=%b%b%b exp=000", c, bus.up, bus.down, bus.tracking);
      end
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.up, bus.down, bus.tracking} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset got up/down/trk=%b%b%b exp=000", bus.up, bus.down, bus.tracking);
    end
  endtask

  task automatic test_track_up();
    bit done = 0;
    bus.game_on = 1'b1; bus.ball_toward = 1'b1; bus.ball_y = POS_W'(500);
    set_pos(300);
    for (int c = 0; c <= 26; c++) begin
      tick();
      checks++;
      if (bus.up !== (c == 26) || bus.down !== 1'b0 || bus.tracking !== 1'b1) begin
        errors++;
        $display("FAIL track_latency c=%0d got up/down/trk=%b%b%b exp=%b01", c, bus.up, bus.down, bus.tracking, (c == 26));
      end
    end
    for (int c = 0; c < 400 && !done; c++) begin
      move_paddle();
      tick();
      checks++;
      if ({bus.up, bus.down, bus.tracking} !== {m_up, m_down, m_mode == 1}) begin
        errors++;
        $display("FAIL track_move c=%0d pos=%0d got %b%b%b exp %b%b%b", c, pp, bus.up, bus.down, bus.tracking, m_up, m_down, m_mode == 1);
      end
      if (!m_up) done = 1;
    end
    checks++;
    if (!done || pp != 500 || bus.up !== 1'b0) begin
      errors++;
      $display("FAIL track_stop got pos=%0d up=%b done=%0d exp pos=500 up=0", pp, bus.up, done);
    end
  endtask

  task automatic test_center_down();
    bit done = 0;
    bus.ball_toward = 1'b0;
    for (int c = 0; c <= 26; c++) begin
      tick();
      checks++;
      if (bus.down !== (c == 26) || bus.up !== 1'b0 || bus.tracking !== 1'b0) begin
        errors++;
        $display("FAIL center_latency c=%0d got up/down/trk=%b%b%b exp 0%b0", c, bus.up, bus.down, bus.tracking, (c == 26));
      end
    end
    for (int c = 0; c < 400 && !done; c++) begin
      move_paddle();
      tick();
      checks++;
      if ({bus.up, bus.down, bus.tracking} !== {m_up, m_down, m_mode == 1}) begin
        errors++;
        $display("FAIL center_move c=%0d pos=%0d got %b%b%b exp %b%b%b", c, pp, bus.up, bus.down, bus.tracking, m_up, m_down, m_mode == 1);
      end
      if (!m_down) done = 1;
    end
    checks++;
    if (!done || pp != 300 || bus.down !== 1'b0) begin
      errors++;
      $display("FAIL center_stop got pos=%0d down=%b done=%0d exp pos=300 down=0", pp, bus.down, done);
    end
  endtask

  task automatic test_deadband();
    bus.ball_y = POS_W'(304); bus.ball_toward = 1'b1;
    set_pos(300);
    for (int c = 0; c < 120; c++) begin
      move_paddle();
      tick();
      checks++;
      if (bus.up !== 1'b0 || bus.down !== 1'b0 || pp != 300) begin
        errors++;
        $display("FAIL deadband c=%0d got up/down=%b%b pos=%0d exp 00 pos=300", c, bus.up, bus.down, pp);
      end
    end
  endtask

  task automatic test_walls();
    bus.ball_y = POS_W'(700);
    set_pos(600);
    for (int c = 0; c < 80; c++) begin
      move_paddle();
      tick();
      checks++;
      if (bus.up !== 1'b0 || bus.up !== m_up || bus.down !== m_down) begin
        errors++;
        $display("FAIL top_wall c=%0d got up/down=%b%b exp 0%b", c, bus.up, bus.down, m_down);
      end
    end
    bus.ball_y = '0;
    set_pos(0);
    for (int c = 0; c < 80; c++) begin
      move_paddle();
      tick();
      checks++;
      if (bus.down !== 1'b0 || bus.up !== m_up || bus.down !== m_down) begin
        errors++;
        $display("FAIL bottom_wall c=%0d got up/down=%b%b exp %b0", c, bus.up, bus.down, m_up);
      end
    end
  endtask

  task automatic test_reset_mid_move();
    bit seen = 0;
    bus.ball_y = POS_W'(560);
    set_pos(500);
    for (int c = 0; c < 120 && !seen; c++) begin
      move_paddle();
      tick();
      checks++;
      if ({bus.up, bus.down} !== {m_up, m_down}) begin
        errors++;
        $display("FAIL pre_reset_move c=%0d got %b%b exp %b%b", c, bus.up, bus.down, m_up, m_down);
      end
      if (bus.up === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL pre_reset_up got up=0 within budget exp up=1");
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.up, bus.down, bus.tracking} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset got up/down/trk=%b%b%b exp=000", bus.up, bus.down, bus.tracking);
    end
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    bus.ball_y = POS_W'(310); bus.ball_toward = 1'b1; bus.game_on = 1'b1;
    set_pos(310);
    reset = 1'b1;
    tick();
    // Aim point after reset is the centre (300), so a paddle at 310 starts down.
    checks++;
    if ({bus.up, bus.down, bus.tracking} !== 3'b011) begin
      errors++;
      $display("FAIL reset_target got up/down/trk=%b%b%b exp=011", bus.up, bus.down, bus.tracking);
    end
  endtask

  task automatic test_gameoff();
    bit seen = 0;
    bus.ball_toward = 1'b0;
    set_pos(500);
    for (int c = 0; c < 60 && !seen; c++) begin
      tick();
      if (bus.down === 1'b1) seen = 1;
      move_paddle();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL gameoff_setup got down=0 within budget exp down=1");
    end
    bus.game_on = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({bus.up, bus.down, bus.tracking} !== 3'b000 || m_mode != 0) begin
        errors++;
        $display("FAIL gameoff c=%0d got up/down/trk=%b%b%b exp=000", c, bus.up, bus.down, bus.tracking);
      end
    end
  endtask

  task automatic test_random();
    bus.game_on = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      bus.game_on = ($urandom_range(99, 0) != 0);
      if ($urandom_range(39, 0) == 0) bus.ball_toward = ~bus.ball_toward;
      bus.ball_y = POS_W'($urandom_range(700, 0));
      if ($urandom_range(149, 0) == 0) set_pos($urandom_range(Y_RES, 0));
      tick();
      checks++;
      if ({bus.up, bus.down, bus.tracking} !== {m_up, m_down, m_mode == 1} || (bus.up && bus.down)) begin
        errors++;
        $display("FAIL random c=%0d pos=%0d got %b%b%b exp %b%b%b", c, pp, bus.up, bus.down, bus.tracking, m_up, m_down, m_mode == 1);
      end
      move_paddle();
    end
  endtask

  initial begin
    test_reset();
    test_track_up();
    test_center_down();
    test_deadband();
    test_walls();
    test_reset_mid_move();
    test_gameoff();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
